// File: rtl/fetch_mem_arbiter.sv
// Round-robin arbiter sharing one pipelined Wishbone slave between NUM_MASTERS masters.
// Grant is held for a whole CYC; a watchdog aborts transactions whose responses never arrive.
module fetch_mem_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int TIMEOUT     = 255
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [NUM_MASTERS-1:0]          m_cyc_i,
  input  logic [NUM_MASTERS-1:0]          m_stb_i,
  input  logic [NUM_MASTERS-1:0]          m_we_i,
  input  logic [NUM_MASTERS*AW-1:0]       m_adr_i,
  input  logic [NUM_MASTERS*DW-1:0]       m_dat_i,
  input  logic [NUM_MASTERS*(DW/8)-1:0]   m_sel_i,
  output logic [DW-1:0]                   m_dat_o,
  output logic [NUM_MASTERS-1:0]          m_ack_o,
  output logic [NUM_MASTERS-1:0]          m_err_o,
  output logic [NUM_MASTERS-1:0]          m_stall_o,
  output logic                            s_cyc_o,
  output logic                            s_stb_o,
  output logic                            s_we_o,
  output logic [AW-1:0]                   s_adr_o,
  output logic [DW-1:0]                   s_dat_o,
  output logic [DW/8-1:0]                 s_sel_o,
  input  logic [DW-1:0]                   s_dat_i,
  input  logic                            s_ack_i,
  input  logic                            s_err_i,
  input  logic                            s_stall_i,
  output logic [$clog2(NUM_MASTERS)-1:0]  grant_o
);

  localparam int GW     = $clog2(NUM_MASTERS);
  localparam int SW     = DW / 8;
  localparam int CW_RAW = $clog2(TIMEOUT + 2);
  localparam int CW     = (CW_RAW < 4) ? 4 : CW_RAW;

  localparam logic [CW-1:0] CNT_ONE     = CW'(1);
  localparam logic [CW-1:0] TIMEOUT_VAL = CW'(TIMEOUT);
  localparam logic [GW:0]   PTR_ONE     = (GW + 1)'(1);

  typedef enum logic [1:0] {IDLE, BUSY, ABORT} state_t;

  state_t                   state;
  logic [GW-1:0]            grant;
  logic [GW-1:0]            ptr;
  logic [GW-1:0]            winner;
  logic                     any_req;
  logic [2*NUM_MASTERS-1:0] req_dbl;
  logic [NUM_MASTERS-1:0]   req_rot;
  logic [CW-1:0]            outst;
  logic [CW-1:0]            outst_next;
  logic [CW-1:0]            wdog;
  logic [CW-1:0]            wdog_inc;
  logic                     gcyc;
  logic                     issue;
  logic                     resp;
  logic                     dec;

  // Rotate requests so bit 0 is the master right after the last owner.
  assign req_dbl = {m_cyc_i, m_cyc_i};
  assign req_rot = NUM_MASTERS'(req_dbl >> ({1'b0, ptr} + PTR_ONE));

  always_comb begin
    any_req = 1'b0;
    winner  = ptr;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (!any_req && req_rot[i]) begin
        any_req = 1'b1;
        winner  = GW'((int'(ptr) + 1 + i) % NUM_MASTERS);
      end
    end
  end

  assign gcyc    = m_cyc_i[grant];
  assign m_dat_o = s_dat_i;
  assign grant_o = grant;

  always_comb begin
    s_cyc_o   = 1'b0;
    s_stb_o   = 1'b0;
    s_we_o    = m_we_i[grant];
    s_adr_o   = m_adr_i[int'(grant)*AW +: AW];
    s_dat_o   = m_dat_i[int'(grant)*DW +: DW];
    s_sel_o   = m_sel_i[int'(grant)*SW +: SW];
    m_stall_o = '1;
    m_ack_o   = '0;
    m_err_o   = '0;
    case (state)
      BUSY: begin
        s_cyc_o          = gcyc;
        s_stb_o          = gcyc & m_stb_i[grant];
        m_stall_o[grant] = s_stall_i;
        m_ack_o[grant]   = s_ack_i;
        m_err_o[grant]   = s_err_i;
      end
      ABORT:   m_err_o[grant] = 1'b1;
      default: ;
    endcase
  end

  // Responses with nothing outstanding are ignored; the counter never wraps.
  assign issue    = s_stb_o & ~s_stall_i;
  assign resp     = s_ack_i | s_err_i;
  assign dec      = resp & (outst != '0);
  assign wdog_inc = wdog + CNT_ONE;

  always_comb begin
    outst_next = outst;
    if (issue && !dec) begin
      if (outst != '1) outst_next = outst + CNT_ONE;
    end else if (!issue && dec) begin
      outst_next = outst - CNT_ONE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      grant <= '0;
      ptr   <= '0;
      outst <= '0;
      wdog  <= '0;
    end else begin
      case (state)
        IDLE: begin
          outst <= '0;
          wdog  <= '0;
          if (any_req) begin
            grant <= winner;
            state <= BUSY;
          end
        end
        BUSY: begin
          if (!gcyc) begin
            state <= IDLE;
            ptr   <= grant;
            outst <= '0;
            wdog  <= '0;
          end else begin
            outst <= outst_next;
            if (resp || outst == '0) begin
              wdog <= '0;
            end else begin
              wdog <= wdog_inc;
              if (TIMEOUT != 0 && wdog_inc == TIMEOUT_VAL) state <= ABORT;
            end
          end
        end
        ABORT: begin
          state <= IDLE;
          ptr   <= grant;
          outst <= '0;
          wdog  <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_mem_arbiter.sv
// Bench for fetch_mem_arbiter: directed scenarios with literal expectations, then random
// traffic checked every cycle against a transaction-level model of the arbitration rules.
module tb_fetch_mem_arbiter;

  localparam int NM  = 3;
  localparam int AW  = 16;
  localparam int DW  = 32;
  localparam int SW  = DW / 8;
  localparam int TMO = 8;

  logic              clk = 1'b0;
  logic              rst_i;
  logic [NM-1:0]     m_cyc_i, m_stb_i, m_we_i;
  logic [NM*AW-1:0]  m_adr_i;
  logic [NM*DW-1:0]  m_dat_i;
  logic [NM*SW-1:0]  m_sel_i;
  logic [DW-1:0]     m_dat_o;
  logic [NM-1:0]     m_ack_o, m_err_o, m_stall_o;
  logic              s_cyc_o, s_stb_o, s_we_o;
  logic [AW-1:0]     s_adr_o;
  logic [DW-1:0]     s_dat_o;
  logic [SW-1:0]     s_sel_o;
  logic [DW-1:0]     s_dat_i;
  logic              s_ack_i, s_err_i, s_stall_i;
  logic [1:0]        grant_o;

  int n_tests = 0;
  int n_fail  = 0;

  fetch_mem_arbiter #(.NUM_MASTERS(NM), .AW(AW), .DW(DW), .TIMEOUT(TMO)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i),
    .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i),
    .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_stall_o(m_stall_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_stall_i(s_stall_i),
    .grant_o(grant_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: who owns the bus, who owned it last, requests in flight, quiet cycles.
  int       gidx = 0, last = 0, pend = 0, quiet = 0;
  bit       owned = 0, abort_ph = 0, synced = 0, found, resp;
  logic [NM-1:0] e_stall, e_ack, e_err;
  logic     e_cyc, e_stb;

  always @(negedge clk) begin
    e_stall = '1; e_ack = '0; e_err = '0; e_cyc = 1'b0; e_stb = 1'b0;
    if (owned) begin
      e_cyc         = m_cyc_i[gidx];
      e_stb         = m_cyc_i[gidx] & m_stb_i[gidx];
      e_stall[gidx] = s_stall_i;
      e_ack[gidx]   = s_ack_i;
      e_err[gidx]   = s_err_i;
    end else if (abort_ph) begin
      e_err[gidx] = 1'b1;
    end
    if (synced) begin
      chk("s_cyc", 64'(s_cyc_o), 64'(e_cyc));
      chk("s_stb", 64'(s_stb_o), 64'(e_stb));
      chk("m_stall", 64'(m_stall_o), 64'(e_stall));
      chk("m_ack", 64'(m_ack_o), 64'(e_ack));
      chk("m_err", 64'(m_err_o), 64'(e_err));
      chk("grant", 64'(grant_o), 64'(gidx));
      chk("m_dat", 64'(m_dat_o), 64'(s_dat_i));
      if (owned && e_stb) begin
        chk("s_adr", 64'(s_adr_o), 64'(m_adr_i[gidx*AW +: AW]));
        chk("s_dat", 64'(s_dat_o), 64'(m_dat_i[gidx*DW +: DW]));
        chk("s_sel", 64'(s_sel_o), 64'(m_sel_i[gidx*SW +: SW]));
        chk("s_we", 64'(s_we_o), 64'(m_we_i[gidx]));
      end
    end
    if (rst_i) begin
      owned = 0; abort_ph = 0; gidx = 0; last = 0; pend = 0; quiet = 0; synced = 1;
    end else if (synced) begin
      if (abort_ph) begin
        abort_ph = 0; last = gidx; pend = 0; quiet = 0;
      end else if (owned) begin
        if (!m_cyc_i[gidx]) begin
          owned = 0; last = gidx; pend = 0; quiet = 0;
        end else begin
          resp  = s_ack_i | s_err_i;
          quiet = (resp || pend == 0) ? 0 : quiet + 1;
          if (resp && pend > 0) pend--;
          if (e_stb && !s_stall_i) pend++;
          if (quiet == TMO) begin owned = 0; abort_ph = 1; end
        end
      end else begin
        found = 0;
        for (int i = 1; i <= NM; i++) begin
          if (!found && m_cyc_i[(last + i) % NM]) begin
            found = 1; gidx = (last + i) % NM;
          end
        end
        if (found) owned = 1;
      end
    end
  end

  int acks, errs, wrs, ack_pct;

  initial begin
    rst_i = 1'b1; m_cyc_i = '0; m_stb_i = '0; m_we_i = '0;
    m_adr_i = '0; m_dat_i = '0; m_sel_i = '0;
    s_dat_i = '0; s_ack_i = 1'b0; s_err_i = 1'b0; s_stall_i = 1'b0;
    repeat (3) tick();
    rst_i = 1'b0; #1;
    chk("rst_grant", 64'(grant_o), 64'd0);
    chk("rst_scyc", 64'(s_cyc_o), 64'd0);
    chk("rst_stall", 64'(m_stall_o), 64'h7);
    chk("rst_ack", 64'(m_ack_o), 64'd0);
    chk("rst_err", 64'(m_err_o), 64'd0);

    // Master 2 alone, then drop: last owner becomes 2; then 0 and 2 request -> wraps to 0.
    m_cyc_i = 3'b100; #1;
    chk("arb_cycle_scyc", 64'(s_cyc_o), 64'd0);
    tick(); #1;
    chk("m2_grant", 64'(grant_o), 64'd2);
    chk("m2_scyc", 64'(s_cyc_o), 64'd1);
    m_cyc_i = 3'b000;
    tick(); m_cyc_i = 3'b101; #1;
    chk("wrap_arb_scyc", 64'(s_cyc_o), 64'd0);
    tick(); #1;
    chk("wrap_grant", 64'(grant_o), 64'd0);

    // Four pipelined reads by master 0, slave answers two cycles after each issue.
    m_cyc_i = 3'b001; acks = 0;
    for (int j = 0; j < 6; j++) begin
      if (j > 0) tick();
      m_stb_i[0]     = (j < 4);
      m_adr_i[15:0]  = 16'(16'h100 + j);
      s_ack_i        = (j >= 2);
      s_dat_i        = 32'(32'hA000 + j);
      #1;
      if (j < 4) chk("rd_adr", 64'(s_adr_o), 64'(16'h100 + j));
      if (m_ack_o[0]) begin
        acks++;
        chk("rd_dat", 64'(m_dat_o), 64'(32'hA000 + j));
      end
    end
    chk("rd_acks", 64'(acks), 64'd4);

    // Master 1 issues a read that is never answered; master 2 waits behind it.
    tick(); m_cyc_i = 3'b000; m_stb_i = '0; s_ack_i = 1'b0;
    tick(); m_cyc_i = 3'b010;
    tick(); m_cyc_i = 3'b110; m_stb_i = 3'b010; m_we_i = '0; #1;
    chk("wd_owner", 64'(grant_o), 64'd1);
    errs = 0;
    for (int k = 1; k <= TMO; k++) begin
      tick(); m_stb_i = '0; #1;
      if (m_err_o != '0) errs++;
    end
    chk("wd_quiet", 64'(errs), 64'd0);
    tick(); #1;
    chk("wd_err", 64'(m_err_o), 64'h2);
    chk("wd_abort_scyc", 64'(s_cyc_o), 64'd0);
    tick(); m_cyc_i = 3'b100; #1;
    chk("wd_arb_scyc", 64'(s_cyc_o), 64'd0);
    tick(); #1;
    chk("wd_next_grant", 64'(grant_o), 64'd2);
    chk("wd_next_scyc", 64'(s_cyc_o), 64'd1);

    // Two reads in flight from master 2, then reset; late ACKs must not reach anyone.
    m_stb_i = 3'b100;
    tick();
    tick(); m_stb_i = '0; rst_i = 1'b1;
    tick(); rst_i = 1'b0; m_cyc_i = '0; s_ack_i = 1'b1; #1;
    chk("rst_mid_scyc", 64'(s_cyc_o), 64'd0);
    chk("rst_mid_stall", 64'(m_stall_o), 64'h7);
    chk("rst_mid_grant", 64'(grant_o), 64'd0);
    chk("rst_mid_ack0", 64'(m_ack_o), 64'd0);
    tick(); #1;
    chk("rst_mid_ack1", 64'(m_ack_o), 64'd0);

    // Write by master 0 held off by three stall cycles.
    tick(); s_ack_i = 1'b0; m_cyc_i = 3'b001;
    wrs = 0;
    for (int j = 0; j < 4; j++) begin
      tick(); m_stb_i = 3'b001; m_we_i = 3'b001; s_stall_i = (j < 3); #1;
      chk("stall_mirror", 64'(m_stall_o), (j < 3) ? 64'h7 : 64'h6);
      if (s_stb_o && !s_stall_i) wrs++;
    end
    tick(); m_stb_i = '0; s_ack_i = 1'b1; #1;
    chk("wr_ack", 64'(m_ack_o), 64'h1);
    chk("one_write", 64'(wrs), 64'd1);
    tick(); s_ack_i = 1'b0; m_cyc_i = '0; m_we_i = '0;

    // Random traffic: alternating chatty and near-silent slave phases.
    for (int c = 0; c < 4000; c++) begin
      tick();
      ack_pct = ((c / 500) % 2 == 0) ? 35 : 2;
      rst_i = ($urandom_range(299) == 0);
      for (int i = 0; i < NM; i++)
        if ($urandom_range(7) == 0) m_cyc_i[i] = ~m_cyc_i[i];
      m_stb_i   = 3'($urandom);
      m_we_i    = 3'($urandom);
      m_adr_i   = 48'({$urandom, $urandom});
      m_dat_i   = {$urandom, $urandom, $urandom};
      m_sel_i   = 12'($urandom);
      s_dat_i   = $urandom;
      s_stall_i = ($urandom_range(3) == 0);
      s_ack_i   = ($urandom_range(99) < ack_pct);
      s_err_i   = ($urandom_range(49) == 0);
    end
    tick();
    rst_i = 1'b0;
    repeat (2) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_mem_arbiter.md
Name: fetch_mem_arbiter

Overview:
- N-master round-robin arbiter that shares one pipelined Wishbone slave port between several masters, e.g. I$ refill, data port and debug.
- Sits between the I$/data-side masters and the single main-memory slave behind the fetch/data interconnects.
- Grant is held for a master's whole bus cycle (CYC asserted).
- A per-cycle watchdog terminates hung transactions with ERR so a dead slave cannot block the CPU.

Parameters:
- NUM_MASTERS, 2, number of requesting masters (2..8).
- AW, 32, address width.
- DW, 32, data width; byte selects are DW/8 bits.
- TIMEOUT, 255, cycles without ACK/ERR, while a request is outstanding, before the watchdog fires; 0 disables it.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- m_cyc_i  in  NUM_MASTERS  per-master CYC.
- m_stb_i  in  NUM_MASTERS  per-master STB.
- m_we_i  in  NUM_MASTERS  per-master WE.
- m_adr_i  in  NUM_MASTERS*AW  packed addresses; master k at [k*AW +: AW].
- m_dat_i  in  NUM_MASTERS*DW  packed write data.
- m_sel_i  in  NUM_MASTERS*DW/8  packed byte selects.
- m_dat_o  out  DW  read data, broadcast to all masters.
- m_ack_o  out  NUM_MASTERS  per-master ACK.
- m_err_o  out  NUM_MASTERS  per-master ERR.
- m_stall_o  out  NUM_MASTERS  per-master STALL.
- s_cyc_o, s_stb_o, s_we_o  out  1  slave CYC/STB/WE.
- s_adr_o  out  AW  slave address.
- s_dat_o  out  DW  slave write data.
- s_sel_o  out  DW/8  slave byte selects.
- s_dat_i  in  DW  slave read data.
- s_ack_i, s_err_i, s_stall_i  in  1  slave responses.
- grant_o  out  $clog2(NUM_MASTERS)  index of current/last owner, for debug.

Behaviour:
- Reset values: state IDLE; grant_o=0; round-robin pointer=0; outstanding=0; watchdog=0; m_ack_o=m_err_o=0; m_stall_o all 1; s_cyc_o=s_stb_o=0.
- Reset mid-transaction drops s_cyc_o the next cycle with no ACK/ERR to any master.
- FSM states: IDLE, BUSY, ABORT.
- IDLE:
  - Requests are m_cyc_i bits.
  - Pick the first requester at or after pointer+1 (mod NUM_MASTERS), searching upward.
  - Register the winner into grant_o and go to BUSY. Arbitration costs 1 cycle; s_cyc_o stays 0 in that cycle.
- BUSY:
  - s_cyc_o = m_cyc_i[grant].
  - s_stb/we/adr/dat/sel are muxed combinationally from the granted master.
  - m_stall_o[grant] = s_stall_i; all other masters see stall=1.
  - m_ack_o[grant] = s_ack_i and m_err_o[grant] = s_err_i; others see 0.
  - m_dat_o = s_dat_i at all times.
- Outstanding counter (width clog2(TIMEOUT+2), minimum 4 bits):
  - +1 on s_stb_o & !s_stall_i.
  - -1 on s_ack_i | s_err_i.
  - Issue and response in the same cycle: net 0.
  - A response with outstanding=0 is ignored and does not underflow.
- BUSY exit:
  - When m_cyc_i[grant] falls: pointer=grant, outstanding cleared, back to IDLE. Any outstanding responses are dropped, per the Wishbone abort rule.
  - Re-arbitration needs the IDLE cycle, so a master cannot hold the bus back-to-back if another master is requesting.
- Watchdog:
  - Counts while in BUSY and outstanding>0.
  - Clears on any s_ack_i or s_err_i, and whenever outstanding=0.
  - When count reaches TIMEOUT, go to ABORT.
- ABORT (1 cycle):
  - s_cyc_o=0.
  - m_err_o[grant]=1 for exactly one cycle.
  - Outstanding and watchdog cleared; pointer=grant; go to IDLE.
  - The master must drop CYC on ERR. If it keeps CYC high, it simply re-requests through normal arbitration.
- Single requester: re-granted after the 1 idle cycle.
- No requester: stay in IDLE with s_cyc_o=0.

Test Plan:
- Single master 0 issues 4 pipelined reads, slave ack latency 2 -> 1 idle cycle then s_cyc_o=1; 4 m_ack_o[0] pulses; m_dat_o matches s_dat_i; grant_o=0.
- Masters 0 and 1 both hold CYC continuously, each cycle 1 transfer -> grants alternate 0,1,0,1, each separated by 1 cycle with s_cyc_o=0; non-granted master sees stall=1 and ack=0.
- NUM_MASTERS=3, pointer=2, masters 0 and 2 request -> grant 0, since the search wraps 2+1 to 0.
- Slave asserts s_stall_i for 3 cycles during a granted write -> master stall mirrors it; outstanding increments only when stall=0; exactly one write reaches the slave.
- TIMEOUT=8, slave never acks an issued read -> on the 8th counting cycle enter ABORT; m_err_o[grant]=1 for 1 cycle; s_cyc_o=0; the other waiting master is granted next.
- rst_i pulsed while outstanding=2 -> next cycle s_cyc_o=0, all stall=1, grant_o=0; later s_ack_i produces no m_ack_o.
